// File: rtl/fp_mac_pkg.sv
// fp_mac_pkg: opcodes and exponent helpers shared by the FP MAC
// pipeline and the FIR datapath. No ports.
package fp_mac_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // largest encodable exponent; saturated mantissa is all ones
  function automatic int fp_sat_exp(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_mac_pipe_clz.sv
// count_lead_zero: leading-zero count from the MSB of din.
// Ports: din (W bits) in; cnt out, equals W when din is zero.
module count_lead_zero #(
  parameter int W = 45
) (
  input  logic [W-1:0]           din,
  output logic [$clog2(W+1)-1:0] cnt
);

  localparam int CW = $clog2(W + 1);

  // scan upward so the highest set bit wins
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_mac_pipe.sv
// fp_mac_pipe: 4-stage FP add/mul/mac/clr pipeline, truncating.
// Ports: clk, rst; in_valid/in_ready, in_op, a_*/b_* operands;
// out_valid/out_ready, y_sgn/y_exp/y_man result, y_ovf/y_unf.
module fp_mac_pipe
  import fp_mac_pkg::*;
#(
  parameter int EXP_W = 6,
  parameter int MAN_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             a_sgn,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [MAN_W-1:0] a_man,
  input  logic             b_sgn,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] b_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y_sgn,
  output logic [EXP_W-1:0] y_exp,
  output logic [MAN_W-1:0] y_man,
  output logic             y_ovf,
  output logic             y_unf
);

  localparam int BIAS = fp_bias(EXP_W);
  localparam int PW   = 2 * MAN_W;
  localparam int RW   = PW + 1;
  localparam int H    = MAN_W / 2;
  localparam int CW   = $clog2(RW + 1);
  localparam int EI   = EXP_W + CW + 2;
  localparam logic signed [EI-1:0] EMAX =
    EI'(fp_sat_exp(EXP_W));

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  typedef struct packed {
    fp_t  v;
    logic ovf;
    logic unf;
  } res_t;

  typedef struct packed {
    logic [1:0]       op;
    logic             sgn_b;
    logic [EXP_W-1:0] exp_b;
    logic [MAN_W-1:0] man_b;
    logic             sgn_s;
    logic [EXP_W-1:0] shamt;
    logic [MAN_W-1:0] man_s;
    logic [PW-1:0]    pp_lo;
    logic [PW-1:0]    pp_hi;
    logic             p_sgn;
    logic [EI-1:0]    p_exp;
  } s1_t;

  // raw value = r / 2^PW * 2^(e - BIAS), e signed
  typedef struct packed {
    logic [1:0]    op;
    logic          sgn;
    logic [EI-1:0] e;
    logic [RW-1:0] r;
  } s2_t;

  typedef struct packed {
    logic [1:0] op;
    res_t       res;
  } s3_t;

  // signed-magnitude add; returns {sign, magnitude with carry}
  function automatic logic [MAN_W+1:0] addsub(
    input logic             sb,
    input logic [MAN_W-1:0] mb,
    input logic             ss,
    input logic [MAN_W-1:0] ms
  );
    if (sb == ss) return {sb, {1'b0, mb} + {1'b0, ms}};
    else if (mb >= ms) return {sb, {1'b0, mb - ms}};
    else return {ss, {1'b0, ms - mb}};
  endfunction

  // normalize so the kept MSB sits at weight 1/2, then clamp
  function automatic res_t pack(
    input logic          sgn,
    input logic [EI-1:0] e,
    input logic [RW-1:0] r,
    input logic [CW-1:0] lz
  );
    res_t                 o;
    logic [RW-1:0]        t;
    logic signed [EI-1:0] en;
    t  = r << lz;
    en = e - EI'(lz) + EI'(1);
    o  = '0;
    if (r != '0) begin
      if (en[EI-1]) begin
        o.unf = 1'b1;
      end else if (en > EMAX) begin
        o.v.sgn = sgn;
        o.v.exp = '1;
        o.v.man = '1;
        o.ovf   = 1'b1;
      end else begin
        o.v.sgn = sgn;
        o.v.exp = en[EXP_W-1:0];
        o.v.man = t[RW-1 -: MAN_W];
      end
    end
    return o;
  endfunction

  logic          adv;
  logic          v1, v2, v3;
  s1_t           r1, r1_d;
  s2_t           r2, r2_d;
  s3_t           r3, r3_d;
  fp_t           acc, acc_d;
  res_t          y_q, y_d, mac;
  logic [CW-1:0] lz3, lz4;
  logic          s4_sgn;
  logic [EI-1:0] s4_e;
  logic [RW-1:0] s4_r;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: pick the larger addend (zero ranks lowest), partial products
  always_comb begin
    logic a_z, b_z, swap;
    a_z  = (a_man == '0);
    b_z  = (b_man == '0);
    swap = a_z || (!b_z && (b_exp > a_exp));
    r1_d       = '0;
    r1_d.op    = in_op;
    r1_d.sgn_b = swap ? b_sgn : a_sgn;
    r1_d.exp_b = swap ? b_exp : a_exp;
    r1_d.man_b = swap ? b_man : a_man;
    r1_d.sgn_s = swap ? a_sgn : b_sgn;
    r1_d.man_s = swap ? a_man : b_man;
    r1_d.shamt = swap ? b_exp - a_exp : a_exp - b_exp;
    r1_d.pp_lo = PW'(a_man) * PW'(b_man[H-1:0]);
    r1_d.pp_hi = PW'(a_man) * PW'(b_man[MAN_W-1:H]);
    r1_d.p_sgn = a_sgn ^ b_sgn;
    r1_d.p_exp = EI'(a_exp) + EI'(b_exp) - EI'(BIAS);
  end

  // S2: align/add for ADD, product sum otherwise
  always_comb begin
    logic [MAN_W-1:0] al;
    logic [MAN_W+1:0] sum;
    logic [PW-1:0]    prod;
    al      = r1.man_s >> r1.shamt;
    sum     = addsub(r1.sgn_b, r1.man_b, r1.sgn_s, al);
    prod    = r1.pp_lo + (r1.pp_hi << H);
    r2_d    = '0;
    r2_d.op = r1.op;
    if (r1.op == OP_ADD) begin
      r2_d.sgn = sum[MAN_W+1];
      r2_d.e   = EI'(r1.exp_b);
      r2_d.r   = {sum[MAN_W:0], {MAN_W{1'b0}}};
    end else begin
      r2_d.sgn = r1.p_sgn;
      r2_d.e   = r1.p_exp;
      r2_d.r   = {1'b0, prod};
    end
  end

  // S3: normalize
  count_lead_zero #(.W(RW)) u_clz3 (
    .din (r2.r),
    .cnt (lz3)
  );

  always_comb begin
    r3_d.op  = r2.op;
    r3_d.res = pack(r2.sgn, r2.e, r2.r, lz3);
  end

  // S4: ACC + p, same align/add/normalize path as ADD
  always_comb begin
    fp_t              p, bg, sm;
    logic             acc_z, p_z, swap;
    logic [MAN_W-1:0] al;
    logic [MAN_W+1:0] sum;
    p      = r3.res.v;
    acc_z  = (acc.man == '0);
    p_z    = (p.man == '0);
    swap   = acc_z || (!p_z && (p.exp > acc.exp));
    bg     = swap ? p : acc;
    sm     = swap ? acc : p;
    al     = sm.man >> (bg.exp - sm.exp);
    sum    = addsub(bg.sgn, bg.man, sm.sgn, al);
    s4_sgn = sum[MAN_W+1];
    s4_e   = EI'(bg.exp);
    s4_r   = {sum[MAN_W:0], {MAN_W{1'b0}}};
  end

  count_lead_zero #(.W(RW)) u_clz4 (
    .din (s4_r),
    .cnt (lz4)
  );

  always_comb begin
    mac     = pack(s4_sgn, s4_e, s4_r, lz4);
    mac.ovf = mac.ovf | r3.res.ovf;
    mac.unf = mac.unf | r3.res.unf;
    y_d     = r3.res;
    acc_d   = acc;
    unique case (1'b1)
      (r3.op == OP_MAC): begin
        y_d   = mac;
        acc_d = mac.v;
      end
      (r3.op == OP_CLR): begin
        y_d   = '0;
        y_d.v = acc;
        acc_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      y_q       <= '0;
      acc       <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      r1        <= r1_d;
      r2        <= r2_d;
      r3        <= r3_d;
      // bubbles leave ACC and the result registers alone
      if (v3) begin
        y_q <= y_d;
        acc <= acc_d;
      end
    end
  end

  assign y_sgn = y_q.v.sgn;
  assign y_exp = y_q.v.exp;
  assign y_man = y_q.v.man;
  assign y_ovf = y_q.ovf;
  assign y_unf = y_q.unf;

endmodule
